// File: rtl/button_debouncer.sv
// Per-channel push-button debouncer: 2-flop synchronizer, 4-state debounce FSM,
// registered press/release pulses and software-clearable sticky press flags.
module button_debouncer #(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                   io_mainClk,
  input  logic                   io_reset,
  input  logic [NUM_BUTTONS-1:0] io_buttons_raw,
  output logic [NUM_BUTTONS-1:0] io_buttons_level,
  output logic [NUM_BUTTONS-1:0] io_buttons_rise,
  output logic [NUM_BUTTONS-1:0] io_buttons_fall,
  output logic [NUM_BUTTONS-1:0] io_event_sticky,
  input  logic [NUM_BUTTONS-1:0] io_event_clear
);

  typedef enum logic [1:0] {
    RELEASED,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } state_t;

  localparam logic                 RAW_IDLE = ACTIVE_LOW;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [NUM_BUTTONS-1:0] sync1, sync2, synced;
  logic [NUM_BUTTONS-1:0] rise_d, fall_d, rise_q, fall_q, sticky_q, level;
  state_t                 state_q [NUM_BUTTONS];
  state_t                 state_d [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_q   [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d   [NUM_BUTTONS];

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      sync1 <= {NUM_BUTTONS{RAW_IDLE}};
      sync2 <= {NUM_BUTTONS{RAW_IDLE}};
    end else begin
      sync1 <= io_buttons_raw;
      sync2 <= sync1;
    end
  end

  assign synced = ACTIVE_LOW ? ~sync2 : sync2;

  // Leaving a settled state already counts the first differing sample, so the
  // arm state completes after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    level  = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level[i]   = (state_q[i] == PRESSED) || (state_q[i] == ARM_RELEASE);
      case (state_q[i])
        RELEASED: begin
          cnt_d[i] = '0;
          if (synced[i]) begin
            state_d[i] = ARM_PRESS;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARM_PRESS: begin
          if (!synced[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          cnt_d[i] = '0;
          if (!synced[i]) begin
            state_d[i] = ARM_RELEASE;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ARM_RELEASE: begin
          if (synced[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= rise_d | (sticky_q & ~io_event_clear);
    end
  end

  assign io_buttons_level = level;
  assign io_buttons_rise  = rise_q;
  assign io_buttons_fall  = fall_q;
  assign io_event_sticky  = sticky_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus randomized bouncing,
// every cycle compared against a run-length reference model.
module tb_button_debouncer;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] raw = 2'b11;
  logic [1:0] clr = 2'b00;
  logic [1:0] level, rise, fall, sticky;

  int checks   = 0;
  int failures = 0;

  button_debouncer #(
    .NUM_BUTTONS    (2),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .io_mainClk      (clk),
    .io_reset        (rst),
    .io_buttons_raw  (raw),
    .io_buttons_level(level),
    .io_buttons_rise (rise),
    .io_buttons_fall (fall),
    .io_event_sticky (sticky),
    .io_event_clear  (clr)
  );

  always #5 clk = ~clk;

  // Reference: a channel flips its level after D consecutive synced samples
  // that disagree with it; any agreeing sample restarts the run.
  logic [1:0] m_sync1 = 2'b11, m_sync2 = 2'b11;
  logic [1:0] m_level = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
  int         m_run [2] = '{0, 0};

  always @(posedge clk) begin
    logic [1:0] s, nl, nr, nf;
    int         nrun [2];
    if (rst) begin
      m_sync1 <= 2'b11; m_sync2 <= 2'b11;
      m_level <= '0; m_rise <= '0; m_fall <= '0; m_sticky <= '0;
      m_run[0] <= 0; m_run[1] <= 0;
    end else begin
      s  = ~m_sync2;
      nl = m_level; nr = '0; nf = '0;
      for (int i = 0; i < 2; i++) begin
        nrun[i] = 0;
        if (s[i] != m_level[i]) begin
          nrun[i] = m_run[i] + 1;
          if (nrun[i] == D) begin
            nrun[i] = 0;
            nl[i]   = s[i];
            if (s[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
          end
        end
      end
      m_level  <= nl; m_rise <= nr; m_fall <= nf;
      m_sticky <= nr | (m_sticky & ~clr);
      m_run[0] <= nrun[0]; m_run[1] <= nrun[1];
      m_sync2  <= m_sync1; m_sync1 <= raw;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("level",  32'(level),  32'(m_level));
    check("rise",   32'(rise),   32'(m_rise));
    check("fall",   32'(fall),   32'(m_fall));
    check("sticky", 32'(sticky), 32'(m_sticky));
    check("rise_and_fall", 32'(rise & fall), 32'd0);
  endtask

  // Steps n edges; reports the first edge where (level & mask) == want,
  // and counts cycles with any rise/fall on mask bits.
  task automatic watch(input int n, input logic [1:0] mask, input logic [1:0] want,
                       output int first, output int nrise, output int nfall);
    first = -1; nrise = 0; nfall = 0;
    for (int e = 1; e <= n; e++) begin
      step();
      if (first < 0 && (level & mask) == want) first = e;
      if ((rise & mask) != 0) nrise++;
      if ((fall & mask) != 0) nfall++;
    end
  endtask

  initial begin
    int first, nr, nf, quiet, hold;
    logic [1:0] cur;

    // Reset with both pins held pressed
    rst = 1'b1; raw = 2'b00;
    repeat (3) step();
    check("reset_level",  32'(level),  32'd0);
    check("reset_sticky", 32'(sticky), 32'd0);
    rst = 1'b0;
    watch(12, 2'b11, 2'b11, first, nr, nf);
    check("reset_press_latency", 32'(first), 32'd10);
    check("reset_press_rises",   32'(nr),    32'd1);

    // Release both, then clear bit 0 sticky only
    raw = 2'b11;
    watch(12, 2'b11, 2'b00, first, nr, nf);
    check("release_latency", 32'(first), 32'd10);
    check("release_falls",   32'(nf),    32'd1);
    clr = 2'b01; step(); clr = 2'b00;
    check("clear_bit0_only", 32'(sticky), 32'b10);
    clr = 2'b10; step(); clr = 2'b00;

    // Clean press of bit 0
    raw = 2'b10;
    watch(12, 2'b01, 2'b01, first, nr, nf);
    check("press_latency",  32'(first),    32'd10);
    check("press_rises",    32'(nr),       32'd1);
    check("press_bit1_idle", 32'(level[1]), 32'd0);
    check("press_sticky",   32'(sticky),   32'b01);
    raw = 2'b11;
    repeat (12) step();

    // Bounce shorter than D on bit 0
    quiet = 0; cur = 2'b11;
    for (int n = 0; n < 50;) begin
      hold = $urandom_range(1, D - 1);
      cur[0] = ~cur[0];
      raw = cur;
      for (int k = 0; k < hold && n < 50; k++, n++) begin
        step();
        if (level != 0 || rise != 0 || fall != 0) quiet++;
      end
    end
    raw = 2'b11;
    repeat (D + 3) begin
      step();
      if (level != 0 || rise != 0 || fall != 0) quiet++;
    end
    check("bounce_quiet", 32'(quiet), 32'd0);

    // Set/clear collision on the accept edge
    clr = 2'b01; raw = 2'b10;
    repeat (10) step();
    check("collision_set_wins", 32'(sticky[0]), 32'd1);
    step();
    check("collision_then_clear", 32'(sticky[0]), 32'd0);
    clr = 2'b00; raw = 2'b11;
    repeat (12) step();

    // Reset while pressed
    raw = 2'b10;
    repeat (12) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_fall",  32'(fall),  32'd0);
    watch(12, 2'b01, 2'b01, first, nr, nf);
    check("repress_latency", 32'(first), 32'd10);
    check("repress_rises",   32'(nr),    32'd1);
    check("repress_falls",   32'(nf),    32'd0);

    // Randomized bouncing, clears and occasional resets
    cur = raw;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      raw = cur;
      clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rst = ($urandom_range(0, 299) == 0);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(D, D + 6) : 1;
      for (int k = 0; k < hold; k++) begin
        step();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
